// File: rtl/enigma_pkg.sv
// Shared constants, tx state encoding and letter conversion for the Enigma serial link.
package enigma_pkg;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned ALPHABET_SIZE = 26;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Indices outside the alphabet are shown as '?'.
  function automatic logic [7:0] idx_to_ascii(input logic [4:0] idx);
    if (idx < 5'(ALPHABET_SIZE))
      return ASCII_A + {3'b000, idx};
    else
      return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; occupancy count drives full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/enigma_tx_path.sv
// Enigma transmit path: letter index -> ASCII -> FIFO -> 8N1 UART, with optional CR/LF every LINE_LEN letters.
module enigma_tx_path
  import enigma_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 16,
  parameter int LINE_LEN     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          char_valid,
  input  logic [4:0]                    char_idx,
  output logic                          char_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LCW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [LCW-1:0] LINE_LAST = (LINE_LEN > 0) ? LCW'(LINE_LEN - 1) : '0;

  tx_state_e      state;
  tx_state_e      state_next;

  logic [7:0]     ascii_in;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;

  logic [CW-1:0]  clk_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift_reg;
  logic           from_fifo;
  logic           cr_pend;
  logic           lf_pend;
  logic [LCW-1:0] line_cnt;

  logic           bit_tick;
  logic           load_en;
  logic [7:0]     load_byte;
  logic           load_from_fifo;
  logic           frame_done;
  logic           line_bit;

  assign ascii_in   = idx_to_ascii(char_idx);
  assign char_ready = ~fifo_full;
  assign fifo_push  = char_valid & ~fifo_full;
  assign bit_tick   = (clk_cnt == CNT_MAX);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ascii_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (char_valid && fifo_full)
      overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next     = state;
    fifo_pop       = 1'b0;
    load_en        = 1'b0;
    load_byte      = '0;
    load_from_fifo = 1'b0;
    frame_done     = 1'b0;
    line_bit       = 1'b1;
    case (state)
      IDLE: begin
        // Pending line break wins over queued letters.
        if (cr_pend) begin
          load_en    = 1'b1;
          load_byte  = ASCII_CR;
          state_next = START;
        end else if (lf_pend) begin
          load_en    = 1'b1;
          load_byte  = ASCII_LF;
          state_next = START;
        end else if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          load_en        = 1'b1;
          load_byte      = fifo_dout;
          load_from_fifo = 1'b1;
          state_next     = START;
        end
      end
      START: begin
        line_bit = 1'b0;
        if (bit_tick)
          state_next = DATA;
      end
      DATA: begin
        line_bit = shift_reg[bit_idx];
        if (bit_tick && bit_idx == 3'd7)
          state_next = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line and busy flag are registered, so both trail the state by one
  // cycle and stay aligned with each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      from_fifo <= 1'b0;
      cr_pend   <= 1'b0;
      lf_pend   <= 1'b0;
      line_cnt  <= '0;
    end else begin
      tx_serial <= line_bit;
      tx_busy   <= (state != IDLE);

      if (state == IDLE || bit_tick)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;

      if (state != DATA)
        bit_idx <= '0;
      else if (bit_tick)
        bit_idx <= bit_idx + 3'd1;

      if (load_en) begin
        shift_reg <= load_byte;
        from_fifo <= load_from_fifo;
        if (cr_pend) begin
          cr_pend <= 1'b0;
          lf_pend <= 1'b1;
        end else if (lf_pend) begin
          lf_pend <= 1'b0;
        end
      end

      if (frame_done && from_fifo && LINE_LEN > 0) begin
        if (line_cnt == LINE_LAST) begin
          line_cnt <= '0;
          cr_pend  <= 1'b1;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end
    end
  end

endmodule
